iram_loader: RTL and testbench

Serial boot loader that drives the instruction-RAM write port of the CPU top level (`iaddr_write`/`idata_write`/`i_write`). It receives a framed program image over an 8N1 UART line, assembles bytes into `width`-bit words, and writes them sequentially from address 0. It holds the CPU in reset while loading. It releases the CPU only after the image checksum verifies.

---
 rtl/iram_loader_pkg.sv | 7 +
 rtl/iram_loader_uart_rx.sv | 74 +++++++
 rtl/iram_loader.sv | 123 ++++++++++++
 tb/tb_iram_loader.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/iram_loader_pkg.sv
// Shared constants and state encodings for the serial instruction-RAM boot loader.
package iram_loader_pkg;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {IDLE, COUNT, DATA, CSUM, DONE, ERR} state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
endpackage

// File: rtl/iram_loader_uart_rx.sv
// 8N1 byte receiver: synchronizer, start-bit glitch rejection, mid-bit sampling.
module uart_rx
    import iram_loader_pkg::*;
#(
    parameter int clks_per_bit = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] data,
    output logic       frame_err
);
    localparam int CW = $clog2(clks_per_bit);
    localparam logic [CW-1:0] HALF = CW'(clks_per_bit / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(clks_per_bit - 1);

    logic            r_s1, r_s2, r_prev;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;
    logic            r_valid, r_ferr;
    rx_state_t       r_state;
    logic            w_fall;

    assign w_fall     = r_prev & ~r_s2;
    assign byte_valid = r_valid;
    assign data       = r_shift;
    assign frame_err  = r_ferr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1    <= 1'b1;
            r_s2    <= 1'b1;
            r_prev  <= 1'b1;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_state <= RX_IDLE;
        end else begin
            r_s1    <= rx;
            r_s2    <= r_s1;
            r_prev  <= r_s2;
            r_valid <= 1'b0;
            case (r_state)
                RX_IDLE: if (w_fall) begin
                    r_cnt   <= '0;
                    r_state <= RX_START;
                end
                RX_START: if (r_cnt == HALF) begin
                    // A start bit that is high again at its centre was a glitch.
                    r_cnt   <= '0;
                    r_bit   <= '0;
                    r_state <= r_s2 ? RX_IDLE : RX_DATA;
                end else r_cnt <= r_cnt + 1'b1;
                RX_DATA: if (r_cnt == FULL) begin
                    r_cnt   <= '0;
                    r_shift <= {r_s2, r_shift[7:1]};
                    r_bit   <= r_bit + 1'b1;
                    if (r_bit == 3'd7) r_state <= RX_STOP;
                end else r_cnt <= r_cnt + 1'b1;
                RX_STOP: if (r_cnt == FULL) begin
                    r_cnt   <= '0;
                    r_valid <= 1'b1;
                    r_ferr  <= ~r_s2;
                    r_state <= RX_IDLE;
                end else r_cnt <= r_cnt + 1'b1;
                default: r_state <= RX_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/iram_loader.sv
// Boot loader: receives a framed, XOR-checksummed image over UART and writes it to instruction RAM.
module iram_loader
    import iram_loader_pkg::*;
#(
    parameter int width        = 16,
    parameter int iaddr_width  = 8,
    parameter int clks_per_bit = 434
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rx,
    output logic [iaddr_width-1:0] iaddr_write,
    output logic [width-1:0]       idata_write,
    output logic                   i_write,
    output logic                   cpu_hold,
    output logic                   busy,
    output logic                   done,
    output logic                   error
);
    localparam int B    = width / 8;
    localparam int KW   = (B > 1) ? $clog2(B) : 1;
    localparam int MAXW = (iaddr_width >= 8) ? 256 : (1 << iaddr_width);

    logic                   w_bv, w_ferr;
    logic [7:0]             w_byte;
    logic [width-1:0]       w_word;
    logic [8:0]             w_n;

    state_t                 r_state;
    logic [width-1:0]       r_word, r_data;
    logic [KW-1:0]          r_k;
    logic [8:0]             r_cnt;
    logic [7:0]             r_csum;
    logic [iaddr_width-1:0] r_addr;
    logic                   r_write, r_hold, r_busy, r_done, r_err;

    uart_rx #(.clks_per_bit(clks_per_bit)) u_rx (
        .clk(clk), .reset(reset), .rx(rx),
        .byte_valid(w_bv), .data(w_byte), .frame_err(w_ferr)
    );

    always_comb begin
        w_word = r_word;
        w_word[r_k*8 +: 8] = w_byte;
    end

    assign w_n = (w_byte == 8'h00) ? 9'(MAXW) : {1'b0, w_byte};

    assign iaddr_write = r_addr;
    assign idata_write = r_data;
    assign i_write     = r_write;
    assign cpu_hold    = r_hold;
    assign busy        = r_busy;
    assign done        = r_done;
    assign error       = r_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_word  <= '0;
            r_data  <= '0;
            r_k     <= '0;
            r_cnt   <= '0;
            r_csum  <= '0;
            r_addr  <= '0;
            r_write <= 1'b0;
            r_hold  <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_write <= 1'b0;
            if (r_write) r_addr <= r_addr + 1'b1;
            if (w_bv) begin
                if (w_ferr && (r_state == COUNT || r_state == DATA || r_state == CSUM)) begin
                    r_state <= ERR;
                    r_busy  <= 1'b0;
                    r_err   <= 1'b1;
                end else begin
                    case (r_state)
                        IDLE, DONE, ERR: if (!w_ferr && w_byte == SYNC_BYTE) begin
                            r_state <= COUNT;
                            r_hold  <= 1'b1;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                            r_err   <= 1'b0;
                        end
                        COUNT: begin
                            r_cnt   <= w_n;
                            r_addr  <= '0;
                            r_csum  <= '0;
                            r_k     <= '0;
                            r_state <= DATA;
                        end
                        DATA: begin
                            r_csum <= r_csum ^ w_byte;
                            r_word <= w_word;
                            if (r_k == KW'(B - 1)) begin
                                r_data  <= w_word;
                                r_write <= 1'b1;
                                r_k     <= '0;
                                r_cnt   <= r_cnt - 1'b1;
                                if (r_cnt == 9'd1) r_state <= CSUM;
                            end else r_k <= r_k + 1'b1;
                        end
                        CSUM: begin
                            r_busy <= 1'b0;
                            if (w_byte == r_csum) begin
                                r_state <= DONE;
                                r_done  <= 1'b1;
                                r_hold  <= 1'b0;
                            end else begin
                                r_state <= ERR;
                                r_err   <= 1'b1;
                            end
                        end
                        default: r_state <= IDLE;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_iram_loader.sv
// Directed bench for iram_loader: UART frames at 8 clocks per bit with hand-computed results.
module tb_iram_loader;
    localparam int CPB = 8;
    // XOR of payload 34 12 78 56 = 0x08
    localparam logic [7:0] GOOD_CS = 8'h08;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rx = 1'b1;
    logic [7:0]  iaddr_write;
    logic [15:0] idata_write;
    logic        i_write, cpu_hold, busy, done, error;

    int checks = 0;
    int errors = 0;
    logic [7:0]  wr_addr[$];
    logic [15:0] wr_data[$];

    iram_loader #(.width(16), .iaddr_width(8), .clks_per_bit(CPB)) dut (
        .clk(clk), .reset(reset), .rx(rx),
        .iaddr_write(iaddr_write), .idata_write(idata_write), .i_write(i_write),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (i_write === 1'b1) begin
        wr_addr.push_back(iaddr_write);
        wr_data.push_back(idata_write);
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        @(negedge clk) rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_ok;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] cs);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h78, 1'b1);
        send_byte(8'h56, 1'b1);
        send_byte(cs, 1'b1);
        repeat (4) @(negedge clk);
    endtask

    task automatic do_reset();
        rx = 1'b1;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic check_good_writes(input string tag);
        checks++;
        if (wr_addr.size() !== 2) begin
            errors++;
            $display("FAIL %s write count: got %0d want 2", tag, wr_addr.size());
        end else begin
            checks++;
            if (wr_addr[0] !== 8'd0 || wr_data[0] !== 16'h1234) begin
                errors++;
                $display("FAIL %s word0: got addr %0d data %h want addr 0 data 1234", tag, wr_addr[0], wr_data[0]);
            end
            checks++;
            if (wr_addr[1] !== 8'd1 || wr_data[1] !== 16'h5678) begin
                errors++;
                $display("FAIL %s word1: got addr %0d data %h want addr 1 data 5678", tag, wr_addr[1], wr_data[1]);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        repeat (100) @(negedge clk);
        checks++;
        if ({cpu_hold, busy, done, error, i_write} !== 5'b10000) begin
            errors++;
            $display("FAIL reset flags: got hold/busy/done/err/wr %b want 10000", {cpu_hold, busy, done, error, i_write});
        end
        checks++;
        if (iaddr_write !== 8'd0 || idata_write !== 16'd0 || wr_addr.size() !== 0) begin
            errors++;
            $display("FAIL reset bus: got addr %0d data %h writes %0d want 0 0 0", iaddr_write, idata_write, wr_addr.size());
        end
    endtask

    task automatic test_good_load();
        wr_addr.delete(); wr_data.delete();
        send_byte(8'hA5, 1'b1);
        checks++;
        if (busy !== 1'b1 || cpu_hold !== 1'b1) begin
            errors++;
            $display("FAIL load busy: got busy %b hold %b want 1 1", busy, cpu_hold);
        end
        send_byte(8'h02, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h78, 1'b1);
        send_byte(8'h56, 1'b1);
        send_byte(GOOD_CS, 1'b1);
        repeat (4) @(negedge clk);
        check_good_writes("good");
        checks++;
        if ({done, cpu_hold, error, busy} !== 4'b1000) begin
            errors++;
            $display("FAIL good status: got done/hold/err/busy %b want 1000", {done, cpu_hold, error, busy});
        end
        checks++;
        if (iaddr_write !== 8'd2) begin
            errors++;
            $display("FAIL good addr after: got %0d want 2", iaddr_write);
        end
    endtask

    task automatic test_bad_checksum();
        wr_addr.delete(); wr_data.delete();
        send_frame(8'h00);
        check_good_writes("badcs");
        checks++;
        if ({done, cpu_hold, error} !== 3'b011) begin
            errors++;
            $display("FAIL badcs status: got done/hold/err %b want 011", {done, cpu_hold, error});
        end
        wr_addr.delete(); wr_data.delete();
        send_frame(GOOD_CS);
        check_good_writes("reload");
        checks++;
        if ({done, cpu_hold, error} !== 3'b100) begin
            errors++;
            $display("FAIL reload status: got done/hold/err %b want 100", {done, cpu_hold, error});
        end
    endtask

    task automatic test_frame_error();
        wr_addr.delete(); wr_data.delete();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h12, 1'b0);
        repeat (20) @(negedge clk);
        checks++;
        if ({done, cpu_hold, error, busy} !== 4'b0110 || wr_addr.size() !== 0) begin
            errors++;
            $display("FAIL framing: got done/hold/err/busy %b writes %0d want 0110 0", {done, cpu_hold, error, busy}, wr_addr.size());
        end
    endtask

    task automatic test_glitch();
        do_reset();
        wr_addr.delete(); wr_data.delete();
        @(negedge clk) rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (150) @(negedge clk);
        checks++;
        if ({cpu_hold, busy, done, error} !== 4'b1000 || wr_addr.size() !== 0) begin
            errors++;
            $display("FAIL glitch: got hold/busy/done/err %b writes %0d want 1000 0", {cpu_hold, busy, done, error}, wr_addr.size());
        end
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        checks++;
        if (busy !== 1'b0 || cpu_hold !== 1'b1) begin
            errors++;
            $display("FAIL junk bytes: got busy %b hold %b want 0 1", busy, cpu_hold);
        end
        send_frame(GOOD_CS);
        check_good_writes("afterjunk");
        checks++;
        if (done !== 1'b1 || cpu_hold !== 1'b0) begin
            errors++;
            $display("FAIL afterjunk status: got done %b hold %b want 1 0", done, cpu_hold);
        end
    endtask

    task automatic test_reset_mid_word();
        wr_addr.delete(); wr_data.delete();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h34, 1'b1);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL midword busy: got %b want 1", busy);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({cpu_hold, busy, done, error, i_write} !== 5'b10000 || iaddr_write !== 8'd0 || idata_write !== 16'd0) begin
            errors++;
            $display("FAIL midword reset: got flags %b addr %0d data %h want 10000 0 0000",
                     {cpu_hold, busy, done, error, i_write}, iaddr_write, idata_write);
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        send_frame(GOOD_CS);
        check_good_writes("postreset");
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL postreset done: got %b want 1", done);
        end
    endtask

    initial begin
        test_reset();
        test_good_load();
        test_bad_checksum();
        test_frame_error();
        test_glitch();
        test_reset_mid_word();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
